// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: picks the writeback result, gates strobes on misaligned
// accesses, exposes a forwarding path to EX and counts retired instructions.
module ex_mem_reg #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_OFF = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_c,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [1:0]        ex_res_sel,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [DATA_W-1:0] mem_pc,
  output logic [REG_AW-1:0] mem_wreg,
  output logic              mem_regwrite,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_addr_err,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       inst_count
);

  logic              valid_reg, regwrite_reg, memread_reg, memwrite_reg, addr_err_reg;
  logic [DATA_W-1:0] result_reg, store_data_reg, pc_reg;
  logic [REG_AW-1:0] wreg_reg;
  logic [31:0]       count_reg;

  logic [DATA_W-1:0] result_next;
  logic              misalign;
  logic              regwrite_next, memread_next, memwrite_next, addr_err_next;

  always_comb begin
    result_next = ex_alu_c;
    case (ex_res_sel)
      2'd1:    result_next = ex_hi;
      2'd2:    result_next = ex_lo;
      2'd3:    result_next = ex_pc + DATA_W'(LINK_OFF);
      default: result_next = ex_alu_c;
    endcase
  end

  // A misaligned access becomes an error marker: no memory strobe and no register write.
  assign misalign      = (ex_memread | ex_memwrite) & (ex_alu_c[1:0] != 2'b00);
  assign addr_err_next = ex_valid & misalign;
  assign memread_next  = ex_valid & ex_memread & ~misalign;
  assign memwrite_next = ex_valid & ex_memwrite & ~misalign;
  assign regwrite_next = ex_valid & ex_regwrite & ~misalign & (ex_wreg != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg      <= 1'b0;
      result_reg     <= '0;
      store_data_reg <= '0;
      pc_reg         <= '0;
      wreg_reg       <= '0;
      regwrite_reg   <= 1'b0;
      memread_reg    <= 1'b0;
      memwrite_reg   <= 1'b0;
      addr_err_reg   <= 1'b0;
      count_reg      <= '0;
    end else if (flush) begin
      // The bubble replaces only the incoming instruction; the one in MEM still retires.
      valid_reg      <= 1'b0;
      result_reg     <= '0;
      store_data_reg <= '0;
      pc_reg         <= '0;
      wreg_reg       <= '0;
      regwrite_reg   <= 1'b0;
      memread_reg    <= 1'b0;
      memwrite_reg   <= 1'b0;
      addr_err_reg   <= 1'b0;
      count_reg      <= count_reg + 32'(valid_reg);
    end else if (!stall) begin
      valid_reg      <= ex_valid;
      result_reg     <= result_next;
      store_data_reg <= ex_store_data;
      pc_reg         <= ex_pc;
      wreg_reg       <= ex_wreg;
      regwrite_reg   <= regwrite_next;
      memread_reg    <= memread_next;
      memwrite_reg   <= memwrite_next;
      addr_err_reg   <= addr_err_next;
      count_reg      <= count_reg + 32'(valid_reg);
    end
  end

  assign mem_valid      = valid_reg;
  assign mem_result     = result_reg;
  assign mem_store_data = store_data_reg;
  assign mem_pc         = pc_reg;
  assign mem_wreg       = wreg_reg;
  assign mem_regwrite   = regwrite_reg;
  assign mem_memread    = memread_reg;
  assign mem_memwrite   = memwrite_reg;
  assign mem_addr_err   = addr_err_reg;
  assign inst_count     = count_reg;

  // Load data only exists after MEM, so a load cannot forward from here.
  assign fwd_valid = regwrite_reg & ~memread_reg;
  assign fwd_reg   = wreg_reg;
  assign fwd_data  = result_reg;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_ex_mem_reg;

  typedef struct packed {
    logic        v;
    logic [31:0] res;
    logic [31:0] sd;
    logic [31:0] pc;
    logic [4:0]  wreg;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        err;
    logic        fv;
    logic [4:0]  freg;
    logic [31:0] fdata;
    logic [31:0] cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid;
  logic [31:0] ex_alu_c, ex_hi, ex_lo, ex_pc, ex_store_data;
  logic [1:0]  ex_res_sel;
  logic [4:0]  ex_wreg;
  logic        ex_regwrite, ex_memread, ex_memwrite;
  logic        mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_addr_err, fwd_valid;
  logic [31:0] mem_result, mem_store_data, mem_pc, fwd_data, inst_count;
  logic [4:0]  mem_wreg, fwd_reg;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  ex_mem_reg #(.DATA_W(32), .REG_AW(5), .LINK_OFF(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_c(ex_alu_c), .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_pc(ex_pc),
    .ex_res_sel(ex_res_sel), .ex_store_data(ex_store_data), .ex_wreg(ex_wreg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
    .mem_pc(mem_pc), .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_addr_err(mem_addr_err),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data), .inst_count(inst_count)
  );

  // Monitor: one comparison per edge that the stimulus announced.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{mem_valid, mem_result, mem_store_data, mem_pc, mem_wreg, mem_regwrite,
            mem_memread, mem_memwrite, mem_addr_err, fwd_valid, fwd_reg, fwd_data, inst_count};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s got v=%0b res=%h sd=%h pc=%h wreg=%0d rw=%0b mr=%0b mw=%0b err=%0b fv=%0b freg=%0d fdata=%h cnt=%0d exp v=%0b res=%h sd=%h pc=%h wreg=%0d rw=%0b mr=%0b mw=%0b err=%0b fv=%0b freg=%0d fdata=%h cnt=%0d",
                 n, a.v, a.res, a.sd, a.pc, a.wreg, a.rw, a.mr, a.mw, a.err, a.fv, a.freg, a.fdata, a.cnt,
                 e.v, e.res, e.sd, e.pc, e.wreg, e.rw, e.mr, e.mw, e.err, e.fv, e.freg, e.fdata, e.cnt);
      end else begin
        $display("ok   %s res=%h wreg=%0d cnt=%0d", n, a.res, a.wreg, a.cnt);
      end
    end
  end

  // Apply current inputs over one edge and queue the expected post-edge state.
  task automatic step(input string n, input logic v, input logic [31:0] res,
                      input logic [31:0] sd, input logic [31:0] pc, input logic [4:0] wreg,
                      input logic rw, input logic mr, input logic mw, input logic err,
                      input logic fv, input logic [31:0] cnt);
    obs_t e;
    @(posedge clk);
    #1;
    e = '{v, res, sd, pc, wreg, rw, mr, mw, err, fv, wreg, res, cnt};
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; ex_valid = 1'b0;
    ex_alu_c = '0; ex_hi = '0; ex_lo = '0; ex_pc = '0; ex_res_sel = 2'd0;
    ex_store_data = '0; ex_wreg = '0; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;

    step("reset0", 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    step("reset1", 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; ex_valid = 1'b1; ex_alu_c = 32'h12; ex_wreg = 5'd3; ex_regwrite = 1'b1;
    ex_pc = 32'h100; ex_store_data = 32'hDEAD;
    step("alu_op", 1, 32'h12, 32'hDEAD, 32'h100, 3, 1, 0, 0, 0, 1, 0);

    ex_res_sel = 2'd1; ex_hi = 32'hAAAA0000; ex_lo = 32'h5555; ex_pc = 32'h3000;
    ex_wreg = 5'd4; ex_alu_c = 32'h20;
    step("sel_hi", 1, 32'hAAAA0000, 32'hDEAD, 32'h3000, 4, 1, 0, 0, 0, 1, 1);
    ex_res_sel = 2'd2;
    step("sel_lo", 1, 32'h5555, 32'hDEAD, 32'h3000, 4, 1, 0, 0, 0, 1, 2);
    ex_res_sel = 2'd3;
    step("sel_link", 1, 32'h3008, 32'hDEAD, 32'h3000, 4, 1, 0, 0, 0, 1, 3);
    ex_pc = 32'hFFFFFFFC;
    step("link_wrap", 1, 32'h4, 32'hDEAD, 32'hFFFFFFFC, 4, 1, 0, 0, 0, 1, 4);

    ex_res_sel = 2'd0; ex_memread = 1'b1; ex_alu_c = 32'h1002; ex_wreg = 5'd5; ex_pc = 32'h40;
    step("load_misalign", 1, 32'h1002, 32'hDEAD, 32'h40, 5, 0, 0, 0, 1, 0, 5);
    ex_alu_c = 32'h1004;
    step("load_aligned", 1, 32'h1004, 32'hDEAD, 32'h40, 5, 1, 1, 0, 0, 0, 6);

    ex_memread = 1'b0; ex_alu_c = 32'h7; ex_wreg = 5'd6; ex_pc = 32'h50;
    step("load_0x7", 1, 32'h7, 32'hDEAD, 32'h50, 6, 1, 0, 0, 0, 1, 7);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_alu_c = 32'h99 + 32'(i); ex_wreg = 5'd9; ex_pc = 32'h60 + 32'(i); ex_memwrite = i[0];
      step("stall_hold", 1, 32'h7, 32'hDEAD, 32'h50, 6, 1, 0, 0, 0, 1, 7);
    end
    flush = 1'b1;
    step("flush_over_stall", 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 8);

    stall = 1'b0; flush = 1'b0; ex_memwrite = 1'b0;
    ex_wreg = 5'd0; ex_regwrite = 1'b1; ex_alu_c = 32'h30; ex_pc = 32'h70;
    step("zero_reg", 1, 32'h30, 32'hDEAD, 32'h70, 0, 0, 0, 0, 0, 0, 8);
    ex_valid = 1'b0; ex_memwrite = 1'b1; ex_alu_c = 32'h40; ex_wreg = 5'd7; ex_regwrite = 1'b0;
    step("bubble_store", 0, 32'h40, 32'hDEAD, 32'h70, 7, 0, 0, 0, 0, 0, 9);
    ex_memwrite = 1'b0;
    step("bubble_no_count", 0, 32'h40, 32'hDEAD, 32'h70, 7, 0, 0, 0, 0, 0, 9);

    ex_valid = 1'b1; ex_memwrite = 1'b1; ex_alu_c = 32'h80; ex_store_data = 32'h1234;
    ex_wreg = 5'd0; ex_pc = 32'h90;
    step("store_aligned", 1, 32'h80, 32'h1234, 32'h90, 0, 0, 0, 1, 0, 0, 9);
    stall = 1'b1; ex_alu_c = 32'h55; ex_pc = 32'hA0;
    step("stall_store", 1, 32'h80, 32'h1234, 32'h90, 0, 0, 0, 1, 0, 0, 9);
    rst = 1'b0;
    step("reset_mid_stall", 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; stall = 1'b0; ex_valid = 1'b0; ex_memwrite = 1'b0; ex_alu_c = '0;
    ex_pc = '0; ex_store_data = '0;
    step("idle_after_reset", 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0 pending", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the EX stage (ALU) and the MEM stage of the pipelined CPU.
- Captures the ALU result, HI/LO and control for one instruction per cycle, and selects the writeback result (ALU c, HI, LO or link address).
- Checks word alignment on memory accesses.
- Exports a forwarding path back to EX and keeps a retired-instruction counter.
- Handles stall (hold) and flush (bubble) requests from the hazard unit.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-file address width.
- LINK_OFF, 8, offset added to ex_pc for the link result (jal/jalr).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low (rst==0 resets at posedge clk)
- stall  input  1  hold all stage registers
- flush  input  1  load a bubble
- ex_valid  input  1  EX holds a real instruction
- ex_alu_c  input  DATA_W  ALU result / memory address
- ex_hi  input  DATA_W  HI register value
- ex_lo  input  DATA_W  LO register value
- ex_pc  input  DATA_W  PC of EX instruction
- ex_res_sel  input  2  0=alu_c, 1=hi, 2=lo, 3=pc+LINK_OFF
- ex_store_data  input  DATA_W  rt value for stores
- ex_wreg  input  REG_AW  destination register
- ex_regwrite  input  1  writes register file
- ex_memread  input  1  load
- ex_memwrite  input  1  store
- mem_valid  output  1  MEM holds a real instruction
- mem_result  output  DATA_W  selected result / address
- mem_store_data  output  DATA_W  registered store data
- mem_pc  output  DATA_W  registered PC
- mem_wreg  output  REG_AW  registered destination
- mem_regwrite  output  1  gated register write
- mem_memread  output  1  gated load strobe
- mem_memwrite  output  1  gated store strobe
- mem_addr_err  output  1  misaligned access captured
- fwd_valid  output  1  forwarding source available
- fwd_reg  output  REG_AW  forwarded register number
- fwd_data  output  DATA_W  forwarded value
- inst_count  output  32  retired-instruction count

Behaviour:
- Update priority at each posedge clk: reset > flush > stall > load.
- Reset (rst==0): every registered output is 0, including inst_count. mem_valid=0, so no strobes are active. A reset asserted mid-stall or mid-flush wins.
- Flush (rst==1, flush==1): bubble is loaded.
  - mem_valid, mem_regwrite, mem_memread, mem_memwrite and mem_addr_err become 0.
  - Data fields (result, store_data, pc, wreg) become 0.
  - Flush overrides stall.
- Stall (flush==0, stall==1): all registers hold their values. inst_count holds.
- Load (flush==0, stall==0): capture on every edge, one-cycle latency.
  - mem_result selected by ex_res_sel: 0→ex_alu_c, 1→ex_hi, 2→ex_lo, 3→ex_pc+LINK_OFF. The add wraps modulo 2^DATA_W.
  - misalign = (ex_memread|ex_memwrite) & (ex_alu_c[1:0]!=0).
  - mem_addr_err = ex_valid & misalign.
  - mem_memread = ex_valid & ex_memread & ~misalign.
  - mem_memwrite = ex_valid & ex_memwrite & ~misalign.
  - mem_regwrite = ex_valid & ex_regwrite & ~misalign & (ex_wreg!=0).
  - mem_valid = ex_valid.
  - If ex_valid==0, all strobes and mem_addr_err load 0.
- Loads and stores never use ex_res_sel!=0; in that case mem_result = address.
- Forwarding is combinational from the registers:
  - fwd_valid = mem_regwrite & ~mem_memread (load data is not available in this stage).
  - fwd_reg = mem_wreg.
  - fwd_data = mem_result.
- inst_count:
  - Increments by 1 at any non-stalled, non-flushed, non-reset edge when mem_valid==1 (the instruction leaving MEM to WB).
  - Wraps 0xFFFFFFFF→0.
  - A flush edge also retires the current mem_valid instruction, because the bubble only replaces the incoming one.

Test Plan:
- Reset then ALU op: rst=0 for 2 cycles, then rst=1, ex_valid=1, ex_alu_c=0x12, ex_res_sel=0, ex_wreg=3, ex_regwrite=1 → one cycle later mem_result=0x12, mem_regwrite=1, fwd_valid=1, fwd_reg=3, fwd_data=0x12; the following edge makes inst_count=1.
- Result select: ex_hi=0xAAAA0000, ex_lo=0x5555, ex_pc=0x3000, sel=1/2/3 on consecutive cycles → mem_result=0xAAAA0000, 0x5555, 0x3008. With ex_pc=0xFFFFFFFC and sel=3 → 0x00000004.
- Misaligned load: ex_memread=1, ex_alu_c=0x1002, ex_regwrite=1 → mem_addr_err=1, mem_memread=0, mem_regwrite=0, fwd_valid=0. Same with ex_alu_c=0x1004 → mem_memread=1, mem_addr_err=0, fwd_valid=0.
- Stall/flush priority: load an instruction with result 0x7, then stall=1 for 3 cycles with changing inputs → outputs frozen at 0x7 and inst_count unchanged. Then stall=1 and flush=1 together → mem_valid=0, all strobes 0.
- $zero and bubble: ex_wreg=0, ex_regwrite=1 → mem_regwrite=0. With ex_valid=0 and ex_memwrite=1 → mem_memwrite=0, and inst_count does not increment on the next edge.
- Reset mid-stall: stall=1 with valid data held, then rst=0 for one edge → all outputs 0, inst_count=0.
